sweep_counter_ctrl: RTL and testbench

Sequencer for the N-bit loadable up/down counter. On a start request it loads a low bound, counts up to a high bound, counts back down, and repeats the triangle sweep a programmed number of times. It then reports completion. It drives the counter's active-low enable and load, direction and load value, and observes the counter's q and rco_b. It sits between the register/control interface and the counter datapath.

---
 rtl/sweep_counter_ctrl.sv | 152 +++++++++++++++
 tb/tb_sweep_counter_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer for an N-bit loadable up/down counter: LOAD lo, count to hi, back to lo, repeat reps times.
// Define SWEEP_CHECK_EN to add a shadow counter that aborts the run with err when the counter disagrees.
module sweep_counter_ctrl #(
    parameter int N      = 4,
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      lo,
    input  logic [N-1:0]      hi,
    input  logic [REPS_W-1:0] reps,
    input  logic              hold,
    input  logic [N-1:0]      cnt_q,
    input  logic              cnt_rco_b,
    output logic              cnt_en_b,
    output logic              cnt_load_b,
    output logic              cnt_up,
    output logic [N-1:0]      cnt_load_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [REPS_W-1:0] sweep_cnt
);

    localparam logic [N-1:0]      ONE_N = 1;
    localparam logic [REPS_W-1:0] ONE_R = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [N-1:0]        lo_r;
    logic [N-1:0]        hi_r;
    logic [REPS_W-1:0]   reps_r;
    logic                accept;
    logic                reject;
    logic                sweep_inc;
    logic                fault;

    assign cnt_load_val = lo_r;

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        reject     = 1'b0;
        sweep_inc  = 1'b0;
        cnt_en_b   = 1'b1;
        cnt_load_b = 1'b1;
        cnt_up     = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (reps != '0)) begin
                        accept   = 1'b1;
                        state_nx = S_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_en_b   = 1'b0;
                cnt_load_b = 1'b0;
                state_nx   = S_UP;
            end
            S_UP: begin
                cnt_en_b = hold;
                if (fault) begin
                    state_nx = S_IDLE;
                end else if (!hold && (cnt_q == hi_r - ONE_N)) begin
                    // The counter reaches hi_r on this edge, so turn around now.
                    state_nx = S_DOWN;
                end
            end
            S_DOWN: begin
                cnt_en_b = hold;
                cnt_up   = 1'b0;
                if (fault) begin
                    state_nx = S_IDLE;
                end else if (!hold && (cnt_q == lo_r + ONE_N)) begin
                    sweep_inc = 1'b1;
                    state_nx  = (sweep_cnt + ONE_R == reps_r) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            reps_r    <= '0;
            sweep_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lo_r      <= lo;
                hi_r      <= hi;
                reps_r    <= reps;
                sweep_cnt <= '0;
            end else if (sweep_inc) begin
                sweep_cnt <= sweep_cnt + ONE_R;
            end
            busy <= (state_nx == S_LOAD) || (state_nx == S_UP) || (state_nx == S_DOWN);
            done <= (state_nx == S_DONE);
            err  <= reject | fault;
        end
    end

`ifdef SWEEP_CHECK_EN
    logic [N-1:0] shadow_q;
    logic         counting;

    assign counting = (state == S_UP) || (state == S_DOWN);
    // rco_b is legitimately low only when counting down has reached zero.
    assign fault = counting &&
                   ((cnt_q != shadow_q) ||
                    (!cnt_rco_b && ((state == S_UP) || (shadow_q != '0))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (state == S_LOAD) begin
            shadow_q <= lo_r;
        end else if (counting && !hold) begin
            shadow_q <= (state == S_UP) ? shadow_q + ONE_N : shadow_q - ONE_N;
        end
    end
`else
    logic unused_rco_b;
    assign unused_rco_b = cnt_rco_b;
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Scoreboard bench for sweep_counter_ctrl with a behavioural model of the attached up/down counter.
module tb_sweep_counter_ctrl;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [3:0] lo    = '0;
    logic [3:0] hi    = '0;
    logic [3:0] reps  = '0;
    logic [3:0] q_m   = 4'd9;
    logic [3:0] fault_ofs = '0;
    logic [3:0] cnt_q;
    logic       cnt_rco_b;
    logic       cnt_en_b, cnt_load_b, cnt_up, busy, done, err;
    logic [3:0] cnt_load_val, sweep_cnt;

    typedef struct packed {
        logic [1:0] kind;   // 0 busy cycle, 1 done, 2 err
        logic       chk_q;
        logic [3:0] q;
        logic [3:0] scnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  errors = 0;
    int  checks = 0;
    logic [1:0] kind_obs;

    sweep_counter_ctrl #(.N(4), .REPS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .reps(reps),
        .hold(hold), .cnt_q(cnt_q), .cnt_rco_b(cnt_rco_b),
        .cnt_en_b(cnt_en_b), .cnt_load_b(cnt_load_b), .cnt_up(cnt_up),
        .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .err(err),
        .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    // Attached counter: no reset, load has priority, counts only when enabled.
    always @(posedge clk) begin
        if (!cnt_en_b) begin
            if (!cnt_load_b) q_m <= cnt_load_val;
            else if (cnt_up) q_m <= q_m + 4'd1;
            else             q_m <= q_m - 4'd1;
        end
    end
    assign cnt_q     = q_m + fault_ofs;
    assign cnt_rco_b = cnt_up ? (q_m != 4'hF) : (q_m != 4'h0);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic c, input logic [3:0] v, input logic [3:0] s);
        exp_q.push_back({k, c, v, s});
    endtask

    // Expected per-cycle trace of one accepted run; hn extra held cycles at q==hq in the first rise.
    task automatic push_run(input int l, input int h, input int r, input int hq, input int hn);
        push(2'd0, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < r; k++) begin
            for (int v = l; v < h; v++) begin
                push(2'd0, 1'b1, 4'(v), 4'd0);
                if (k == 0 && v == hq)
                    for (int j = 0; j < hn; j++) push(2'd0, 1'b1, 4'(v), 4'd0);
            end
            for (int v = h; v > l; v--) push(2'd0, 1'b1, 4'(v), 4'd0);
        end
        push(2'd1, 1'b1, 4'(l), 4'(r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int l, input int h, input int r);
        lo = 4'(l); hi = 4'(h); reps = 4'(r); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // Monitor: every cycle with busy/done/err is one observed event.
    always @(negedge clk) begin
        if (!rst && (busy || done || err)) begin
            kind_obs = err ? 2'd2 : (done ? 2'd1 : 2'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d, expected none", kind_obs);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", int'(kind_obs), int'(e.kind));
                if (e.chk_q) check("counter_q", int'(q_m), int'(e.q));
                if (e.kind == 2'd1) check("done_sweep_cnt", int'(sweep_cnt), int'(e.scnt));
                if (e.kind == 2'd2) begin
                    check("err_busy", int'(busy), 0);
                    check("err_en_b", int'(cnt_en_b), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs[11] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5};
        #1 rst = 1'b1;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_en_b", int'(cnt_en_b), 1);
        check("rst_load_b", int'(cnt_load_b), 1);
        check("rst_up", int'(cnt_up), 1);
        check("rst_load_val", int'(cnt_load_val), 0);
        check("rst_sweep_cnt", int'(sweep_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Basic two-sweep run; a start during the run must be ignored.
        push_run(3, 6, 2, -1, 0);
        start_run(3, 6, 2);
        repeat (3) tick();
        lo = 4'd5; hi = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        drain("sweep_3_6_x2");

        // Rejected starts.
        push(2'd2, 1'b0, 4'd0, 4'd0);
        start_run(5, 5, 1);
        drain("reject_lo_eq_hi");
        push(2'd2, 1'b0, 4'd0, 4'd0);
        start_run(3, 6, 0);
        drain("reject_reps_zero");
        check("idle_en_b", int'(cnt_en_b), 1);

        // Hold for three cycles while q=4 in the rise.
        push_run(3, 6, 1, 4, 3);
        start_run(3, 6, 1);
        tick();
        tick();
        hold = 1'b1;
        repeat (3) tick();
        hold = 1'b0;
        drain("hold_at_4");

        // Top-of-range bounds.
        push_run(14, 15, 1, -1, 0);
        start_run(14, 15, 1);
        drain("sweep_14_15");
        push_run(0, 15, 1, -1, 0);
        start_run(0, 15, 1);
        drain("sweep_0_15");

        // Asynchronous reset in the second DOWN phase.
        push(2'd0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 11; i++) push(2'd0, 1'b1, 4'(rs[i]), 4'd0);
        start_run(3, 6, 2);
        repeat (11) tick();
        @(negedge clk);
        #1;
        check("pre_rst_sweep_cnt", int'(sweep_cnt), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_en_b", int'(cnt_en_b), 1);
        check("mid_rst_load_b", int'(cnt_load_b), 1);
        check("mid_rst_up", int'(cnt_up), 1);
        check("mid_rst_sweep_cnt", int'(sweep_cnt), 0);
        check("mid_rst_load_val", int'(cnt_load_val), 0);
        check("mid_rst_pending", exp_q.size(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        push_run(3, 6, 1, -1, 0);
        start_run(3, 6, 1);
        drain("after_rst_sweep");

        // Counter reads one high for a single cycle while q=5 in the rise.
`ifdef SWEEP_CHECK_EN
        push(2'd0, 1'b0, 4'd0, 4'd0);
        push(2'd0, 1'b1, 4'd3, 4'd0);
        push(2'd0, 1'b1, 4'd4, 4'd0);
        push(2'd0, 1'b1, 4'd5, 4'd0);
        push(2'd2, 1'b0, 4'd0, 4'd0);
`else
        push_run(3, 10, 1, -1, 0);
`endif
        start_run(3, 10, 1);
        repeat (3) tick();
        fault_ofs = 4'd1;
        tick();
        fault_ofs = 4'd0;
        drain("fault_inject");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
